// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter between the CPU memory stage and a host port.
package dmem_arb_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_HOST = 2'd2
    } grant_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has zero-latency priority, a starvation
// counter guarantees host progress, and HOLD hands the memory to the host outright.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | CPU-priority arbitration; host wins after MAX_WAIT lost conflicts
//   HOLD  | host owns the memory; any CPU request is stalled
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_valid,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_hold,
    output logic              hold_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    arb_state_t        state, state_nxt;
    grant_t            grant;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            host_rvalid <= host_ready && !host_we;
            if (host_ready && !host_we) begin
                host_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant        = GNT_NONE;
        wait_cnt_nxt = '0;

        case (state)
            RUN: begin
                if (host_hold) begin
                    state_nxt = HOLD;
                end
                if (cpu_req && host_valid) begin
                    if (wait_cnt == WAIT_LIMIT) begin
                        grant = GNT_HOST;
                    end else begin
                        grant        = GNT_CPU;
                        wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else if (cpu_req) begin
                    grant = GNT_CPU;
                end else if (host_valid) begin
                    grant = GNT_HOST;
                end
            end
            HOLD: begin
                if (!host_hold) begin
                    state_nxt = RUN;
                end
                if (host_valid) begin
                    grant = GNT_HOST;
                end
            end
            default: state_nxt = RUN;
        endcase

        // Reset blocks every grant so no write can land while rst is low.
        if (!rst) begin
            grant = GNT_NONE;
        end
    end

    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        host_ready = 1'b0;
        cpu_rdata  = mem_rdata;
        case (grant)
            GNT_CPU: begin
                mem_we = cpu_we;
            end
            GNT_HOST: begin
                mem_we     = host_we;
                mem_addr   = host_addr;
                mem_wdata  = host_wdata;
                host_ready = 1'b1;
            end
            default: ;
        endcase
        cpu_stall = rst && cpu_req && (grant != GNT_CPU);
    end

    assign hold_ack = (state == HOLD);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a rule-level model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req, cpu_we, host_valid, host_we, host_hold;
    logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;

    logic        cpu_stall, host_ready, host_rvalid, hold_ack, mem_we;
    logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall0, host_ready0, host_rvalid0, hold_ack0, mem_we0;
    logic [31:0] cpu_rdata0, host_rdata0, mem_addr0, mem_wdata0, mem_rdata0;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign mem_rdata  = mem_a[mem_addr[9:2]];
    assign mem_rdata0 = mem_b[mem_addr0[9:2]];
    always @(posedge clk) if (mem_we)  mem_a[mem_addr[9:2]]  <= mem_wdata;
    always @(posedge clk) if (mem_we0) mem_b[mem_addr0[9:2]] <= mem_wdata0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .host_hold(host_hold), .hold_ack(hold_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata0), .cpu_stall(cpu_stall0),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready0), .host_rvalid(host_rvalid0), .host_rdata(host_rdata0),
        .host_hold(host_hold), .hold_ack(hold_ack0),
        .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_valid = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_hold = 0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic host_op(input logic we, input logic [31:0] a, input logic [31:0] d);
        host_valid = 1; host_we = we; host_addr = a; host_wdata = d;
    endtask

    task automatic test_reset();
        cpu_op(1, 32'h10, 32'h1111); host_op(1, 32'h20, 32'h2222);
        next_cycle();
        tests++; if (mem_we !== 1'b0 || mem_we0 !== 1'b0) begin fails++; $display("FAIL reset_mem_we: got %b/%b exp 0", mem_we, mem_we0); end
        tests++; if (host_ready !== 1'b0) begin fails++; $display("FAIL reset_host_ready: got %b exp 0", host_ready); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_cpu_stall: got %b exp 0", cpu_stall); end
        tests++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h0) begin fails++; $display("FAIL reset_host_rd: got %b/%h exp 0/0", host_rvalid, host_rdata); end
        tests++; if (hold_ack !== 1'b0) begin fails++; $display("FAIL reset_hold_ack: got %b exp 0", hold_ack); end
        idle();
        rst = 1;
        next_cycle();
    endtask

    task automatic test_cpu_only();
        cpu_op(1, 32'h10, 32'hDEADBEEF);
        #1;
        tests++; if (cpu_stall !== 1'b0 || mem_we !== 1'b1) begin fails++; $display("FAIL cpu_store: stall %b we %b exp 0 1", cpu_stall, mem_we); end
        next_cycle();
        cpu_op(0, 32'h10, 32'h0);
        #1;
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL cpu_load_stall: got %b exp 0", cpu_stall); end
        tests++; if (cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL cpu_load_data: got %h exp deadbeef", cpu_rdata); end
        next_cycle();
        idle();
    endtask

    task automatic test_host_only();
        host_op(1, 32'h20, 32'h1234);
        #1;
        tests++; if (host_ready !== 1'b1) begin fails++; $display("FAIL host_write_ready: got %b exp 1", host_ready); end
        next_cycle();
        host_op(0, 32'h20, 32'h0);
        #1;
        tests++; if (host_ready !== 1'b1) begin fails++; $display("FAIL host_read_ready: got %b exp 1", host_ready); end
        tests++; if (host_rvalid !== 1'b0) begin fails++; $display("FAIL host_write_no_rvalid: got %b exp 0", host_rvalid); end
        next_cycle();
        idle();
        tests++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h1234) begin fails++; $display("FAIL host_read_data: got %b/%h exp 1/1234", host_rvalid, host_rdata); end
        next_cycle();
        tests++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h1234) begin fails++; $display("FAIL host_rvalid_pulse: got %b/%h exp 0/1234", host_rvalid, host_rdata); end
    endtask

    task automatic test_starvation();
        cpu_op(0, 32'h10, 32'h0);
        host_op(1, 32'h24, 32'hA5A5);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) host_op(1, 32'h28, 32'h5A5A);
            #1;
            tests++;
            if (host_ready !== (i == 4) || cpu_stall !== (i == 4)) begin
                fails++; $display("FAIL starve_cycle%0d: ready %b stall %b exp %b", i, host_ready, cpu_stall, (i == 4));
            end
            if (i != 4) begin
                tests++; if (cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL starve_cpu_data%0d: got %h exp deadbeef", i, cpu_rdata); end
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_hold();
        cpu_op(0, 32'h10, 32'h0);
        host_hold = 1;
        #1;
        tests++; if (hold_ack !== 1'b0 || cpu_stall !== 1'b0) begin fails++; $display("FAIL hold_entry_cycle: ack %b stall %b exp 0 0", hold_ack, cpu_stall); end
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            host_op(1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i));
            #1;
            tests++;
            if (hold_ack !== 1'b1 || cpu_stall !== 1'b1 || host_ready !== 1'b1 || mem_we !== 1'b1) begin
                fails++; $display("FAIL hold_write%0d: ack %b stall %b ready %b we %b exp 1 1 1 1", i, hold_ack, cpu_stall, host_ready, mem_we);
            end
            next_cycle();
        end
        host_valid = 0; host_hold = 0;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL hold_exit_cycle: stall %b exp 1", cpu_stall); end
        next_cycle();
        tests++; if (hold_ack !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL hold_released: ack %b stall %b data %h exp 0 0 deadbeef", hold_ack, cpu_stall, cpu_rdata);
        end
        next_cycle();
        cpu_op(0, 32'h4C, 32'h0);
        #1;
        tests++; if (cpu_rdata !== 32'h103) begin fails++; $display("FAIL hold_written_data: got %h exp 103", cpu_rdata); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_max_wait0();
        cpu_op(0, 32'h10, 32'h0);
        host_op(0, 32'h20, 32'h0);
        #1;
        tests++; if (host_ready0 !== 1'b1 || cpu_stall0 !== 1'b1) begin fails++; $display("FAIL mw0_host_wins: ready %b stall %b exp 1 1", host_ready0, cpu_stall0); end
        tests++; if (host_ready !== 1'b0 || cpu_stall !== 1'b0) begin fails++; $display("FAIL mw4_cpu_wins: ready %b stall %b exp 0 0", host_ready, cpu_stall); end
        next_cycle();
        idle();
        tests++; if (host_rvalid0 !== 1'b1 || host_rdata0 !== 32'h1234) begin fails++; $display("FAIL mw0_read: got %b/%h exp 1/1234", host_rvalid0, host_rdata0); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        host_op(0, 32'h20, 32'h0);
        #1;
        tests++; if (host_ready !== 1'b1) begin fails++; $display("FAIL midrst_handshake: got %b exp 1", host_ready); end
        #1;
        rst = 0;
        host_op(1, 32'h20, 32'h0BAD);
        #1;
        tests++; if (mem_we !== 1'b0 || host_ready !== 1'b0) begin fails++; $display("FAIL midrst_forced: we %b ready %b exp 0 0", mem_we, host_ready); end
        next_cycle();
        tests++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h0 || hold_ack !== 1'b0) begin
            fails++; $display("FAIL midrst_regs: rvalid %b rdata %h ack %b exp 0 0 0", host_rvalid, host_rdata, hold_ack);
        end
        idle();
        rst = 1;
        next_cycle();
        cpu_op(0, 32'h20, 32'h0);
        #1;
        tests++; if (cpu_rdata !== 32'h1234) begin fails++; $display("FAIL midrst_no_write: got %h exp 1234", cpu_rdata); end
        next_cycle();
        idle();
        next_cycle();
    endtask

    // Model tracks winners by the arbitration rules; memory contents via its own array.
    task automatic test_random();
        logic [31:0] ref_mem [0:15];
        int  losses = 0;
        bit  in_hold = 0;
        logic [31:0] exp_rdata = 32'h0;
        bit  exp_rv;
        bit  cpu_win, host_win;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            host_op(1, 32'h100 + 32'(4 * i), ref_mem[i]);
            next_cycle();
        end
        idle();
        next_cycle();
        for (int n = 0; n < 600; n++) begin
            if (!cpu_req && ($urandom_range(0, 2) != 0))
                cpu_op(1'($urandom), 32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom);
            if (!host_valid && $urandom_range(0, 1) == 1)
                host_op(1'($urandom), 32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 15) == 0) host_hold = !host_hold;
            #1;
            host_win = 0; cpu_win = 0;
            if (in_hold) host_win = host_valid;
            else if (cpu_req && host_valid) begin
                if (losses >= 4) host_win = 1; else cpu_win = 1;
            end else begin
                cpu_win = cpu_req; host_win = host_valid;
            end
            tests++;
            if (cpu_stall !== (cpu_req && !cpu_win) || host_ready !== host_win || hold_ack !== in_hold) begin
                fails++; $display("FAIL rand_grant@%0d: stall %b ready %b ack %b exp %b %b %b", n, cpu_stall, host_ready, hold_ack, cpu_req && !cpu_win, host_win, in_hold);
            end
            if (cpu_win && !cpu_we) begin
                tests++; if (cpu_rdata !== ref_mem[cpu_addr[5:2]]) begin fails++; $display("FAIL rand_cpu_load@%0d: got %h exp %h", n, cpu_rdata, ref_mem[cpu_addr[5:2]]); end
            end
            exp_rv = host_win && !host_we;
            if (exp_rv) exp_rdata = ref_mem[host_addr[5:2]];
            if (cpu_win && cpu_we) ref_mem[cpu_addr[5:2]] = cpu_wdata;
            if (host_win && host_we) ref_mem[host_addr[5:2]] = host_wdata;
            if (in_hold || !host_valid || host_win) losses = 0;
            else losses++;
            in_hold = host_hold;
            next_cycle();
            tests++;
            if (host_rvalid !== exp_rv || host_rdata !== exp_rdata) begin
                fails++; $display("FAIL rand_host_read@%0d: got %b/%h exp %b/%h", n, host_rvalid, host_rdata, exp_rv, exp_rdata);
            end
            if (cpu_win) cpu_req = 0;
            if (host_win) host_valid = 0;
        end
        idle();
        next_cycle();
    endtask

    initial begin
        idle();
        rst = 0;
        test_reset();
        test_cpu_only();
        test_host_only();
        test_starvation();
        test_hold();
        test_max_wait0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
